xregf_arb: RTL and testbench
============================

// Module: xregf_arb
//
// PURPOSE
//   Two-master arbiter in front of the xregf register file. Master A (picoVersat
//   controller) and master B (host/debug port) each issue single-word read/write
//   accesses. The arbiter grants one master per cycle, using round-robin with a
//   bounded lock for bursts. It drives the regf sel/we/addr/data_in inputs and
//   returns registered read data to the winning master.
//
// PARAMETERS
//   DATA_W       `DATA_W       data word width (regf data_in/data_out)
//   REGF_ADDR_W  `REGF_ADDR_W  regf address width
//   MAX_LOCK     8             max consecutive locked transfers before forced release (>=1)
//
// PORTS
//   clk          in   1            clock, all state on rising edge
//   rst_n        in   1            asynchronous reset, active-low
//   a_req        in   1            A access request (valid)
//   a_we         in   1            A write enable (1=write, 0=read)
//   a_lock       in   1            A requests to keep grant after this transfer
//   a_addr       in   REGF_ADDR_W  A register address
//   a_wdata      in   DATA_W       A write data
//   a_ack        out  1            A granted (ready); transfer when a_req&a_ack
//   a_rdata      out  DATA_W       A read data, registered
//   a_rvalid     out  1            1-cycle pulse, a_rdata valid
//   b_*          --   --           identical set for master B
//   regf_sel     out  1            to xregf sel
//   regf_we      out  1            to xregf we
//   regf_addr    out  REGF_ADDR_W  to xregf addr
//   regf_wdata   out  DATA_W       to xregf data_in
//   regf_rdata   in   DATA_W       from xregf data_out (combinational)
//
// BEHAVIOUR
//   - FSM states: IDLE, GNT_A, GNT_B. Register last (last granted master).
//     Register lock_cnt (0..MAX_LOCK).
//   - Reset (async, rst_n=0): state=IDLE, last=B (A wins first tie), lock_cnt=0,
//     a/b_rvalid=0, a/b_rdata=0. a/b_ack=0 and regf_sel=0 follow from IDLE.
//   - a_ack=(state==GNT_A), b_ack=(state==GNT_B). Both acks are decoded from state
//     registers only, so ack never depends combinationally on req.
//   - Transfer xfer_x = x_req & x_ack. regf_sel=xfer_A|xfer_B.
//     regf_we/addr/wdata are muxed from the granted master. When no master is
//     granted, they are 0.
//   - Writes: regf is updated at the edge ending the transfer cycle.
//   - Reads: regf_rdata is captured into x_rdata at that edge. x_rvalid=1 for
//     exactly the next cycle. Latency: req seen in IDLE at edge N -> ack in
//     cycle N+1 -> rdata/rvalid in cycle N+2.
//   - Arbitration (IDLE, or on release from a grant):
//     - If only one master requests, that master wins.
//     - If both request, the master != last wins.
//     - If neither requests, go to IDLE.
//   - IDLE: arbitrate; the winner's GNT state is entered next cycle and last is
//     updated to the winner.
//   - GNT_x, xfer_x & x_lock & lock_cnt<MAX_LOCK-1: stay in GNT_x, lock_cnt++.
//   - GNT_x, xfer_x & (!x_lock | lock_cnt==MAX_LOCK-1): release.
//     - lock_cnt=0.
//     - Arbitrate with last=x, so the other master wins if it requests.
//     - Back-to-back hand-over with no IDLE cycle.
//   - Forced release at MAX_LOCK:
//     - Applies only if the other master requests.
//     - If the other master is idle, x keeps the grant and lock_cnt saturates at
//       MAX_LOCK-1.
//   - GNT_x, !x_req (master withdrew): release as above, no regf access that cycle.
//   - Simultaneous a/b requests arriving on the same edge: resolved by last only.
//     Never grant both.
//   - Reset mid-transfer: access aborted. A write not yet clocked is lost.
//     Pending rvalid is cleared.
//   - Invariants:
//     - a_ack & b_ack == 0 always.
//     - regf_sel=0 whenever no transfer.
//     - At most one of a_rvalid/b_rvalid per cycle.
//
// TESTING
//   1. Reset with both reqs high -> first grant A (a_ack cycle 1), then B.
//      No ack during rst_n=0.
//   2. A writes 0xDEADBEEF to r3, then B reads r3 -> b_rvalid one cycle with
//      b_rdata=0xDEADBEEF.
//   3. Both requesting continuously, lock=0 -> grants alternate A,B,A,B with no
//      IDLE gap. Each master sees exactly 1 ack per 2 cycles.
//   4. A lock=1 for 20 transfers, B requesting, MAX_LOCK=8 -> A gets 8 acks, then
//      B is granted. With B idle, A keeps all 20.
//   5. A read r5=0x12 with rst_n pulsed low in the ack cycle -> a_rvalid never
//      asserts. State IDLE, all outputs 0.
//   6. B withdraws req while in GNT_B -> no regf_sel that cycle. Grant moves to A
//      if A requests, else IDLE.

Source files
------------

// File: rtl/xregf_arb_if.sv
// Bus bundle between the two access masters, the arbiter and the xregf register file.
// The arbiter takes the slave view; whoever drives the masters and models regf takes master.
interface xregf_arb_if #(
  parameter int DATA_W      = 32,
  parameter int REGF_ADDR_W = 4
);
  logic                   a_req, a_we, a_lock, a_ack, a_rvalid;
  logic [REGF_ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0]      a_wdata, a_rdata;

  logic                   b_req, b_we, b_lock, b_ack, b_rvalid;
  logic [REGF_ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0]      b_wdata, b_rdata;

  logic                   regf_sel, regf_we;
  logic [REGF_ADDR_W-1:0] regf_addr;
  logic [DATA_W-1:0]      regf_wdata, regf_rdata;

  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    input  regf_rdata,
    output a_ack, a_rdata, a_rvalid,
    output b_ack, b_rdata, b_rvalid,
    output regf_sel, regf_we, regf_addr, regf_wdata
  );

  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    output regf_rdata,
    input  a_ack, a_rdata, a_rvalid,
    input  b_ack, b_rdata, b_rvalid,
    input  regf_sel, regf_we, regf_addr, regf_wdata
  );
endinterface

// File: rtl/xregf_arb.sv
// Two-master round-robin arbiter with bounded burst lock in front of xregf.
// One master is granted per cycle; read data comes back registered one cycle later.

// Per-master read-return register: captures regf data on a read transfer and
// raises rvalid for exactly the following cycle.
module xregf_arb_port #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en_i,
  input  logic [DATA_W-1:0] regf_rdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o
);
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_en_i;
      if (rd_en_i) rdata_q <= regf_rdata_i;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
endmodule

module xregf_arb #(
  parameter int DATA_W      = 32,
  parameter int REGF_ADDR_W = 4,
  parameter int MAX_LOCK    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  xregf_arb_if.slave  bus
);
  localparam int NM  = 2;
  localparam int LCW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK + 1) : 1;
  localparam logic [LCW-1:0] LOCK_TOP = LCW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_e;

  typedef struct packed {
    logic                   we;
    logic                   lock;
    logic [REGF_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]      wdata;
  } req_t;

  req_t   [NM-1:0]             rq;
  logic   [NM-1:0]             req_v, ack, xfer, rd_en, rvalid;
  logic   [NM-1:0][DATA_W-1:0] rdata;

  state_e         state_q, state_d;
  logic           last_q, last_d;      // 0 = A, 1 = B
  logic [LCW-1:0] cnt_q, cnt_d;

  assign rq[0]    = '{we: bus.a_we, lock: bus.a_lock, addr: bus.a_addr, wdata: bus.a_wdata};
  assign rq[1]    = '{we: bus.b_we, lock: bus.b_lock, addr: bus.b_addr, wdata: bus.b_wdata};
  assign req_v    = {bus.b_req, bus.a_req};
  assign xfer     = req_v & ack;

  // Returns {found, winner}; on a tie the master that was not served last wins.
  function automatic logic [1:0] arb(input logic ra, input logic rb, input logic lst);
    if (ra && rb) return {1'b1, ~lst};
    else if (ra)  return 2'b10;
    else if (rb)  return 2'b11;
    else          return 2'b00;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  logic       cur, oth, do_arb, arb_last;
  logic [1:0] win;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    cur      = (state_q == GNT_B);
    oth      = ~cur;
    do_arb   = 1'b0;
    arb_last = last_q;
    win      = 2'b00;
    unique case (state_q)
      IDLE: do_arb = 1'b1;
      GNT_A, GNT_B: begin
        arb_last = cur;
        if (!xfer[cur]) begin
          do_arb = 1'b1;
          cnt_d  = '0;
        end else if (rq[cur].lock && cnt_q < LOCK_TOP) begin
          cnt_d = cnt_q + LCW'(1);
        end else if (rq[cur].lock && !req_v[oth]) begin
          // Lock budget spent but nobody is waiting: keep the grant, hold the count.
          cnt_d = LOCK_TOP;
        end else begin
          do_arb = 1'b1;
          cnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_arb) begin
      win = arb(req_v[0], req_v[1], arb_last);
      if (win[1]) begin
        state_d = win[0] ? GNT_B : GNT_A;
        last_d  = win[0];
      end else begin
        state_d = IDLE;
      end
    end
  end

  logic                   regf_we;
  logic [REGF_ADDR_W-1:0] regf_addr;
  logic [DATA_W-1:0]      regf_wdata;

  always_comb begin
    ack        = '0;
    regf_we    = 1'b0;
    regf_addr  = '0;
    regf_wdata = '0;
    unique case (state_q)
      GNT_A: begin
        ack        = 2'b01;
        regf_we    = rq[0].we;
        regf_addr  = rq[0].addr;
        regf_wdata = rq[0].wdata;
      end
      GNT_B: begin
        ack        = 2'b10;
        regf_we    = rq[1].we;
        regf_addr  = rq[1].addr;
        regf_wdata = rq[1].wdata;
      end
      default: ;
    endcase
    for (int i = 0; i < NM; i++) rd_en[i] = xfer[i] & ~rq[i].we;
  end

  for (genvar i = 0; i < NM; i++) begin : g_port
    xregf_arb_port #(.DATA_W(DATA_W)) u_port (
      .clk          (clk),
      .rst_n        (rst_n),
      .rd_en_i      (rd_en[i]),
      .regf_rdata_i (bus.regf_rdata),
      .rdata_o      (rdata[i]),
      .rvalid_o     (rvalid[i])
    );
  end

  assign bus.a_ack      = ack[0];
  assign bus.b_ack      = ack[1];
  assign bus.a_rdata    = rdata[0];
  assign bus.b_rdata    = rdata[1];
  assign bus.a_rvalid   = rvalid[0];
  assign bus.b_rvalid   = rvalid[1];
  assign bus.regf_sel   = |xfer;
  assign bus.regf_we    = regf_we;
  assign bus.regf_addr  = regf_addr;
  assign bus.regf_wdata = regf_wdata;

  a_one_ack:    assert property (@(posedge clk) disable iff (!rst_n) !(ack[0] && ack[1]));
  a_one_rvalid: assert property (@(posedge clk) disable iff (!rst_n) !(rvalid[0] && rvalid[1]));
endmodule

// File: tb/tb_xregf_arb.sv
// Directed bench for xregf_arb: reset, handover, lock bursts, withdrawal, mid-access reset.
// A small register array stands in for xregf behind the arbiter.
module tb_xregf_arb;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   n, na, nb;

  always #5 clk = ~clk;

  xregf_arb_if #(.DATA_W(DW), .REGF_ADDR_W(AW)) bus ();

  xregf_arb #(.DATA_W(DW), .REGF_ADDR_W(AW), .MAX_LOCK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] regs [16] = '{default: '0};
  always @(posedge clk) if (bus.regf_sel && bus.regf_we) regs[bus.regf_addr] <= bus.regf_wdata;
  assign bus.regf_rdata = regs[bus.regf_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("ack_excl", 32'(bus.a_ack & bus.b_ack), 0);
    chk("rvalid_excl", 32'(bus.a_rvalid & bus.b_rvalid), 0);
  endtask

  task automatic drv_a(input logic req, we, lock, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bus.a_req = req; bus.a_we = we; bus.a_lock = lock; bus.a_addr = addr; bus.a_wdata = wd;
  endtask

  task automatic drv_b(input logic req, we, lock, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bus.b_req = req; bus.b_we = we; bus.b_lock = lock; bus.b_addr = addr; bus.b_wdata = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with both masters requesting reads of r0
    rst_n = 1'b0;
    drv_a(1, 0, 0, 0, 0);
    drv_b(1, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_a_ack", bus.a_ack, 0);
    chk("rst_b_ack", bus.b_ack, 0);
    chk("rst_sel", bus.regf_sel, 0);
    chk("rst_a_rvalid", bus.a_rvalid, 0);
    chk("rst_b_rdata", bus.b_rdata, 0);
    rst_n = 1'b1;

    // First grant goes to A, then alternation with no gap
    step(); #1;
    chk("t1_a_ack", bus.a_ack, 1);
    chk("t1_b_ack", bus.b_ack, 0);
    chk("t1_sel", bus.regf_sel, 1);
    step(); #1;
    chk("t1_b_ack2", bus.b_ack, 1);
    chk("t1_a_rvalid", bus.a_rvalid, 1);
    step(); #1;
    chk("t3_a_ack", bus.a_ack, 1);
    chk("t3_b_rvalid", bus.b_rvalid, 1);
    chk("t3_a_rvalid", bus.a_rvalid, 0);
    na = 0; nb = 0;
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      na += int'(bus.a_ack);
      nb += int'(bus.b_ack);
      chk("t3_sel", bus.regf_sel, 1);
    end
    chk("t3_a_acks", na, 2);
    chk("t3_b_acks", nb, 2);

    // B granted, both withdraw: no access, then IDLE
    step();
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    #1;
    chk("t6_b_ack", bus.b_ack, 1);
    chk("t6_sel_withdraw", bus.regf_sel, 0);
    step(); #1;
    chk("t6_idle_a", bus.a_ack, 0);
    chk("t6_idle_b", bus.b_ack, 0);
    chk("t6_idle_sel", bus.regf_sel, 0);

    // A writes DEADBEEF to r3, B reads it back
    drv_a(1, 1, 0, 3, 32'hDEADBEEF);
    #1;
    chk("t2_idle_sel", bus.regf_sel, 0);
    step();
    drv_b(1, 0, 0, 3, 0);
    #1;
    chk("t2_a_ack", bus.a_ack, 1);
    chk("t2_we", bus.regf_we, 1);
    chk("t2_addr", bus.regf_addr, 3);
    chk("t2_wdata", bus.regf_wdata, 32'hDEADBEEF);
    step();
    drv_a(0, 0, 0, 0, 0);
    #1;
    chk("t2_b_ack", bus.b_ack, 1);
    chk("t2_b_sel", bus.regf_sel, 1);
    chk("t2_b_we", bus.regf_we, 0);
    chk("t2_a_rvalid_wr", bus.a_rvalid, 0);
    step();
    drv_b(0, 0, 0, 0, 0);
    #1;
    chk("t2_b_rvalid", bus.b_rvalid, 1);
    chk("t2_b_rdata", bus.b_rdata, 32'hDEADBEEF);
    step(); #1;
    chk("t2_b_rvalid_off", bus.b_rvalid, 0);
    chk("t2_b_rdata_hold", bus.b_rdata, 32'hDEADBEEF);
    chk("t2_idle", bus.b_ack, 0);

    // B withdraws while granted, A waiting takes over
    drv_b(1, 0, 0, 3, 0);
    step();
    drv_b(0, 0, 0, 0, 0);
    drv_a(1, 0, 0, 3, 0);
    #1;
    chk("t6b_b_ack", bus.b_ack, 1);
    chk("t6b_sel", bus.regf_sel, 0);
    step(); #1;
    chk("t6b_a_ack", bus.a_ack, 1);
    chk("t6b_sel_a", bus.regf_sel, 1);
    chk("t6b_b_rvalid", bus.b_rvalid, 0);
    step();
    drv_a(0, 0, 0, 0, 0);
    #1;
    chk("t6b_a_rvalid", bus.a_rvalid, 1);
    chk("t6b_a_rdata", bus.a_rdata, 32'hDEADBEEF);
    step(); #1;
    chk("t6b_idle", bus.a_ack, 0);

    // Locked burst by A with B waiting: 8 transfers then B
    drv_a(1, 0, 1, 1, 0);
    step();
    drv_b(1, 0, 0, 3, 0);
    #1;
    n = 0;
    for (int i = 0; i < 30 && bus.a_ack; i++) begin
      n++;
      step(); #1;
    end
    chk("t4_lock_len", n, 8);
    chk("t4_b_after", bus.b_ack, 1);
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    step(); #1;
    chk("t4_idle", bus.a_ack | bus.b_ack, 0);

    // Locked burst with B idle: A keeps grant, then saturated lock yields to B
    drv_a(1, 0, 1, 1, 0);
    step(); #1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      n += int'(bus.a_ack);
      step(); #1;
    end
    chk("t4b_a_acks", n, 20);
    chk("t4b_still_a", bus.a_ack, 1);
    drv_b(1, 0, 0, 3, 0);
    step();
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    #1;
    chk("t4b_b_ack", bus.b_ack, 1);
    chk("t4b_a_ack", bus.a_ack, 0);
    step(); #1;
    chk("t4b_idle", bus.a_ack | bus.b_ack, 0);

    // Write r5=0x12, then reset in the read's ack cycle
    drv_a(1, 1, 0, 5, 32'h12);
    step(); step();
    drv_a(1, 0, 0, 5, 0);
    #1;
    chk("t5_a_ack", bus.a_ack, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ack", bus.a_ack, 0);
    chk("t5_rst_sel", bus.regf_sel, 0);
    step();
    rst_n = 1'b1;
    drv_a(0, 0, 0, 0, 0);
    #1;
    chk("t5_rvalid", bus.a_rvalid, 0);
    chk("t5_rdata", bus.a_rdata, 0);
    step(); #1;
    chk("t5_rvalid2", bus.a_rvalid, 0);
    chk("t5_acks", bus.a_ack | bus.b_ack, 0);
    chk("t5_sel", bus.regf_sel, 0);
    chk("t5_we", bus.regf_we, 0);
    chk("t5_addr", bus.regf_addr, 0);
    chk("t5_wdata", bus.regf_wdata, 0);
    chk("t5_r5", regs[5], 32'h12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
